// File: rtl/sixty_four_bit_adder_subtractor_pkg.sv
// Shared datapath types for the Booth multiplier and its add/subtract stage.
package sixty_four_bit_adder_subtractor_pkg;

  localparam int DATA_W = 64;

  typedef logic [DATA_W-1:0] word64_t;

endpackage

// File: rtl/sixty_four_bit_adder_subtractor_if.sv
// Operand/result bundle between the Booth controller (master) and the adder (slave).
interface sixty_four_bit_adder_subtractor_if;
  import sixty_four_bit_adder_subtractor_pkg::*;

  logic    cin;
  word64_t onesComp_ip;
  word64_t i0;
  word64_t sum;

  modport master (
    output cin,
    output onesComp_ip,
    output i0,
    input  sum
  );

  modport slave (
    input  cin,
    input  onesComp_ip,
    input  i0,
    output sum
  );

endinterface

// File: rtl/sixty_four_bit_adder_subtractor_full_adder.sv
// One ripple-carry stage.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/sixty_four_bit_adder_subtractor.sv
// Registered i0 + onesComp_ip + cin, modulo 2^WIDTH; the caller supplies the
// one's complement of the subtrahend, so no operand is ever inverted here.
module sixty_four_bit_adder_subtractor
  import sixty_four_bit_adder_subtractor_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  sixty_four_bit_adder_subtractor_if.slave  bus
);

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_q;
  logic             carry_unused;

  assign carry[0] = bus.cin;

  // Stage WIDTH-1 carry-out is the discarded bit 64 of the full sum.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == WIDTH - 1) begin : g_last
      full_adder u_fa (
        .a  (bus.i0[i]),
        .b  (bus.onesComp_ip[i]),
        .ci (carry[i]),
        .s  (s[i]),
        .co (carry_unused)
      );
    end else begin : g_mid
      full_adder u_fa (
        .a  (bus.i0[i]),
        .b  (bus.onesComp_ip[i]),
        .ci (carry[i]),
        .s  (s[i]),
        .co (carry[i+1])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= s;
    end
  end

  assign bus.sum = sum_q;

endmodule

// File: tb/tb_sixty_four_bit_adder_subtractor.sv
// Directed-vector bench for the registered 64-bit adder/subtractor.
module tb_sixty_four_bit_adder_subtractor;
  import sixty_four_bit_adder_subtractor_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  sixty_four_bit_adder_subtractor_if bus ();

  sixty_four_bit_adder_subtractor #(.WIDTH(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input word64_t a, input word64_t b, input logic c);
    @(negedge clk);
    bus.i0          = a;
    bus.onesComp_ip = b;
    bus.cin         = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    word64_t exp;
    #1;
    rst_n = 1'b0;
    bus.i0 = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.onesComp_ip = '0;
    bus.cin = 1'b0;
    #1;
    vectors++;
    if (bus.sum !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_async got=%h exp=%h", bus.sum, 64'h0);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.sum !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_hold got=%h exp=%h", bus.sum, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp = 64'hFFFF_FFFF_FFFF_FFFF;
    step(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
    vectors++;
    if (bus.sum !== exp) begin
      miscompares++;
      $display("FAIL reset_first_capture got=%h exp=%h", bus.sum, exp);
    end
  endtask

  task automatic test_zero();
    step(64'h0, 64'h0, 1'b0);
    vectors++;
    if (bus.sum !== 64'h0) begin
      miscompares++;
      $display("FAIL zero got=%h exp=%h", bus.sum, 64'h0);
    end
  endtask

  task automatic test_wrap();
    step(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    vectors++;
    if (bus.sum !== 64'h0) begin
      miscompares++;
      $display("FAIL wrap_cin got=%h exp=%h", bus.sum, 64'h0);
    end
    step(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    vectors++;
    if (bus.sum !== 64'h0) begin
      miscompares++;
      $display("FAIL wrap_msb got=%h exp=%h", bus.sum, 64'h0);
    end
  endtask

  task automatic test_complementary();
    step(64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
    vectors++;
    if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL complementary got=%h exp=%h", bus.sum, 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_subtract();
    step(64'd10, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    vectors++;
    if (bus.sum !== 64'd7) begin
      miscompares++;
      $display("FAIL sub_10_minus_3 got=%h exp=%h", bus.sum, 64'd7);
    end
    step(64'd3, 64'hFFFF_FFFF_FFFF_FFF5, 1'b1);
    vectors++;
    if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFF9) begin
      miscompares++;
      $display("FAIL sub_3_minus_10 got=%h exp=%h", bus.sum, 64'hFFFF_FFFF_FFFF_FFF9);
    end
  endtask

  task automatic test_back_to_back();
    word64_t a_t [5];
    word64_t b_t [5];
    logic    c_t [5];
    word64_t e_t [5];
    a_t[0] = 64'd1;                   b_t[0] = 64'd2;  c_t[0] = 1'b0; e_t[0] = 64'd3;
    a_t[1] = 64'h1234_5678_9ABC_DEF0; b_t[1] = 64'd1;  c_t[1] = 1'b1; e_t[1] = 64'h1234_5678_9ABC_DEF2;
    a_t[2] = 64'h7FFF_FFFF_FFFF_FFFF; b_t[2] = 64'd1;  c_t[2] = 1'b0; e_t[2] = 64'h8000_0000_0000_0000;
    a_t[3] = 64'h0000_0000_FFFF_FFFF; b_t[3] = 64'd0;  c_t[3] = 1'b1; e_t[3] = 64'h0000_0001_0000_0000;
    a_t[4] = 64'hAAAA_AAAA_AAAA_AAAA; b_t[4] = 64'h5555_5555_5555_5555; c_t[4] = 1'b1; e_t[4] = 64'h0;
    for (int i = 0; i < 5; i++) begin
      step(a_t[i], b_t[i], c_t[i]);
      vectors++;
      if (bus.sum !== e_t[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, bus.sum, e_t[i]);
      end
    end
    // Inputs toggling between edges must not disturb the held result.
    #2;
    bus.i0 = 64'h1111_2222_3333_4444;
    bus.onesComp_ip = 64'h5;
    bus.cin = 1'b1;
    #1;
    vectors++;
    if (bus.sum !== e_t[4]) begin
      miscompares++;
      $display("FAIL hold_between_edges got=%h exp=%h", bus.sum, e_t[4]);
    end
  endtask

  task automatic test_mid_op_reset();
    step(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b0);
    vectors++;
    if (bus.sum !== 64'h100) begin
      miscompares++;
      $display("FAIL pre_reset got=%h exp=%h", bus.sum, 64'h100);
    end
    @(negedge clk);
    bus.i0 = 64'h0000_0000_0000_0042;
    bus.onesComp_ip = 64'h0;
    bus.cin = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.sum !== 64'h0) begin
      miscompares++;
      $display("FAIL mid_op_reset got=%h exp=%h", bus.sum, 64'h0);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.sum !== 64'h0) begin
      miscompares++;
      $display("FAIL in_flight_lost got=%h exp=%h", bus.sum, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(64'd20, 64'd22, 1'b0);
    vectors++;
    if (bus.sum !== 64'd42) begin
      miscompares++;
      $display("FAIL post_reset got=%h exp=%h", bus.sum, 64'd42);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1;
    bus.i0 = '0;
    bus.onesComp_ip = '0;
    bus.cin = 1'b0;
    test_reset();
    test_zero();
    test_wrap();
    test_complementary();
    test_subtract();
    test_back_to_back();
    test_mid_op_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
